// File: rtl/conv_window_mac_pkg.sv
// rtl/conv_window_mac_pkg.sv - shared geometry, widths and load-FSM state type for conv_window_mac
package conv_window_mac_pkg;

    localparam int KX     = 5;
    localparam int KY     = 5;
    localparam int IX     = 28;
    localparam int IY     = 28;
    localparam int I_F_BW = 8;
    localparam int W_BW   = 8;
    localparam int B_BW   = 16;
    localparam int O_F_BW = 16;

    localparam int N_TAPS  = KX * KY;
    localparam int WIN_BW  = N_TAPS * I_F_BW;
    // Pixel is zero-extended by one bit before the signed multiply.
    localparam int PROD_BW = I_F_BW + W_BW + 1;
    localparam int ROW_BW  = PROD_BW + $clog2(KX);
    localparam int ACC_BW  = PROD_BW + $clog2(N_TAPS);

    localparam int ST1_W_BW   = W_BW;
    localparam int ST1_B_BW   = B_BW;
    localparam int ST1_O_F_BW = O_F_BW;
    localparam int ST1_ACC_BW = ACC_BW;
    localparam int ST1_OX     = IX - KX + 1;
    localparam int ST1_OY     = IY - KY + 1;

    localparam int N_OUT  = ST1_OX * ST1_OY;
    localparam int IDX_BW = $clog2(N_TAPS + 1);
    localparam int CNT_BW = $clog2(N_OUT);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COPY  = 2'd2,
        ST_READY = 2'd3
    } load_state_e;

endpackage

// File: rtl/conv_window_mac_if.sv
// rtl/conv_window_mac_if.sv - window/weight input and feature output bundle for conv_window_mac
// slave  : the MAC (consumes window + weight load, produces o_ready/o_drop/o_valid/o_feature/o_last)
// master : the producer/consumer side around the MAC
interface conv_window_mac_if;
    import conv_window_mac_pkg::*;

    logic                i_window_valid;
    logic [WIN_BW-1:0]   i_window;
    logic                i_w_valid;
    logic [W_BW-1:0]     i_w_data;
    logic [B_BW-1:0]     i_b_data;
    logic                o_ready;
    logic                o_drop;
    logic                o_valid;
    logic [O_F_BW-1:0]   o_feature;
    logic                o_last;

    modport slave (
        input  i_window_valid, i_window, i_w_valid, i_w_data, i_b_data,
        output o_ready, o_drop, o_valid, o_feature, o_last
    );

    modport master (
        output i_window_valid, i_window, i_w_valid, i_w_data, i_b_data,
        input  o_ready, o_drop, o_valid, o_feature, o_last
    );

endinterface

// File: rtl/conv_row_dot.sv
// rtl/conv_row_dot.sv - one KX-wide window row: registered products, then registered row sum
// clk, reset_n : clock, async active-low reset
// i_pixels     : KX unsigned pixels, element wx at [wx*I_F_BW +: I_F_BW]
// i_weights    : KX signed weights, same ordering
// o_row_sum    : signed row dot product, two cycles after the inputs
module conv_row_dot
    import conv_window_mac_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [KX*I_F_BW-1:0]      i_pixels,
    input  logic [KX*W_BW-1:0]        i_weights,
    output logic signed [ROW_BW-1:0]  o_row_sum
);

    logic signed [PROD_BW-1:0] prod_c [KX];
    logic signed [PROD_BW-1:0] prod_q [KX];
    logic signed [ROW_BW-1:0]  sum_c;

    always_comb begin
        for (int k = 0; k < KX; k++) begin
            prod_c[k] = PROD_BW'($signed({1'b0, i_pixels[k*I_F_BW +: I_F_BW]}))
                      * PROD_BW'($signed(i_weights[k*W_BW +: W_BW]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < KX; k++) prod_q[k] <= '0;
        end else begin
            for (int k = 0; k < KX; k++) prod_q[k] <= prod_c[k];
        end
    end

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < KX; k++) sum_c = sum_c + ROW_BW'(prod_q[k]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) o_row_sum <= '0;
        else          o_row_sum <= sum_c;
    end

endmodule

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - stage-1 conv MAC: weight/bias bank, 4-stage window pipeline, activation
// clk, reset_n : clock, async active-low reset
// bus (slave)  : window stream in, weight/bias load strobe in, o_ready/o_drop, o_valid/o_feature/o_last out
// CNN_CONV_RELU_EN : when defined, output is ReLU + unsigned saturation; otherwise signed saturation
module conv_window_mac
    import conv_window_mac_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    conv_window_mac_if.slave   bus
);

    load_state_e               state, state_nx;
    logic [IDX_BW-1:0]         idx, wr_idx;
    logic                      wr_en, copy_en, leave_ready, ready_c;
    logic [N_TAPS*W_BW-1:0]    shadow_w, active_w;
    logic signed [B_BW-1:0]    shadow_b, active_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_EMPTY;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_EMPTY: if (bus.i_w_valid) state_nx = ST_LOAD;
            ST_LOAD:  if (bus.i_w_valid && idx == IDX_BW'(N_TAPS)) state_nx = ST_COPY;
            ST_COPY:  state_nx = ST_READY;
            ST_READY: if (bus.i_w_valid) state_nx = ST_LOAD;
            default:  state_nx = ST_EMPTY;
        endcase
    end

    // The strobe that starts a load (from EMPTY or READY) is itself index 0.
    always_comb begin
        ready_c     = (state == ST_READY);
        copy_en     = (state == ST_COPY);
        wr_en       = bus.i_w_valid && (state != ST_COPY);
        leave_ready = ready_c && bus.i_w_valid;
        wr_idx      = (state == ST_LOAD) ? idx : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            shadow_w <= '0;
            shadow_b <= '0;
            active_w <= '0;
            active_b <= '0;
        end else begin
            if (wr_en) begin
                if (wr_idx == IDX_BW'(N_TAPS)) begin
                    shadow_b <= bus.i_b_data;
                    idx      <= '0;
                end else begin
                    shadow_w[int'(wr_idx)*W_BW +: W_BW] <= bus.i_w_data;
                    idx <= wr_idx + 1'b1;
                end
            end
            if (copy_en) begin
                active_w <= shadow_w;
                active_b <= shadow_b;
            end
        end
    end

    // ---------------- window pipeline ----------------
    logic                      accept;
    logic [2:0]                vld_sr;
    logic signed [B_BW-1:0]    bias_s1, bias_s2;
    logic signed [ROW_BW-1:0]  row_sum [KY];
    logic signed [ACC_BW-1:0]  total_c, total_s3;
    logic [O_F_BW-1:0]         sat_c, feature_q;
    logic                      drop_q, valid_q, last_q;
    logic [CNT_BW-1:0]         out_cnt;
    logic                      at_max;

    assign accept = bus.i_window_valid && ready_c;

    for (genvar r = 0; r < KY; r++) begin : g_row
        conv_row_dot u_row (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_pixels  (bus.i_window[r*KX*I_F_BW +: KX*I_F_BW]),
            .i_weights (active_w[r*KX*W_BW +: KX*W_BW]),
            .o_row_sum (row_sum[r])
        );
    end

    always_comb begin
        total_c = ACC_BW'(bias_s2);
        for (int r = 0; r < KY; r++) total_c = total_c + ACC_BW'(row_sum[r]);
    end

    always_comb begin
        sat_c = total_s3[O_F_BW-1:0];
`ifdef CNN_CONV_RELU_EN
        if (total_s3 < 0)
            sat_c = '0;
        else if (total_s3 > ACC_BW'((2**O_F_BW) - 1))
            sat_c = '1;
`else
        if (total_s3 > ACC_BW'((2**(O_F_BW-1)) - 1))
            sat_c = {1'b0, {(O_F_BW-1){1'b1}}};
        else if (total_s3 < -ACC_BW'(2**(O_F_BW-1)))
            sat_c = {1'b1, {(O_F_BW-1){1'b0}}};
`endif
    end

    assign at_max = (out_cnt == CNT_BW'(N_OUT - 1));

    // Bias travels with the window so a bank copy cannot mix banks within one output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr    <= '0;
            bias_s1   <= '0;
            bias_s2   <= '0;
            total_s3  <= '0;
            feature_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            drop_q    <= 1'b0;
            out_cnt   <= '0;
        end else begin
            vld_sr   <= {vld_sr[1:0], accept};
            bias_s1  <= active_b;
            bias_s2  <= bias_s1;
            total_s3 <= total_c;
            drop_q   <= bus.i_window_valid && !ready_c;
            valid_q  <= vld_sr[2];
            last_q   <= vld_sr[2] && at_max;
            if (vld_sr[2]) feature_q <= sat_c;
            if (leave_ready)
                out_cnt <= '0;
            else if (vld_sr[2])
                out_cnt <= at_max ? '0 : out_cnt + 1'b1;
        end
    end

    assign bus.o_ready   = ready_c;
    assign bus.o_drop    = drop_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_feature = feature_q;
    assign bus.o_last    = last_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// tb/tb_conv_window_mac.sv - scoreboard bench for conv_window_mac
module tb_conv_window_mac;
    import conv_window_mac_pkg::*;

    typedef struct {
        logic [O_F_BW-1:0] feat;
        int                cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    conv_window_mac_if bus();

    conv_window_mac dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   tb_w[N_TAPS];
    int   tb_b = 0;
    bit   exp_ready = 1'b0;
    int   exp_oc = 0;
    int   exp_drops = 0;
    int   drops_seen = 0;
    int   lasts_seen = 0;
    int   valids_seen = 0;
    exp_t mon_e;
    bit   mon_last;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.o_drop) drops_seen++;
            if (bus.o_valid) begin
                valids_seen++;
                if (bus.o_last) lasts_seen++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got feature=%0d at cycle %0d, required no output", bus.o_feature, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    mon_last = (exp_oc == N_OUT - 1);
                    exp_oc = mon_last ? 0 : exp_oc + 1;
                    if (bus.o_feature !== mon_e.feat || bus.o_last !== mon_last || cyc != mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL out_check: got feature=%0d last=%0b cycle=%0d, required feature=%0d last=%0b cycle=%0d",
                                 bus.o_feature, bus.o_last, cyc, mon_e.feat, mon_last, mon_e.cyc);
                    end
                end
            end
        end
    end

    function automatic logic [O_F_BW-1:0] model(input logic [WIN_BW-1:0] win);
        int acc;
        acc = tb_b;
        for (int i = 0; i < N_TAPS; i++) acc += int'(win[i*I_F_BW +: I_F_BW]) * tb_w[i];
`ifdef CNN_CONV_RELU_EN
        if (acc < 0) acc = 0;
        else if (acc > 65535) acc = 65535;
`else
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`endif
        return O_F_BW'(acc);
    endfunction

    function automatic logic [WIN_BW-1:0] rand_win();
        logic [WIN_BW-1:0] w;
        for (int i = 0; i < N_TAPS; i++) w[i*I_F_BW +: I_F_BW] = I_F_BW'($urandom);
        return w;
    endfunction

    function automatic logic [WIN_BW-1:0] fill_win(input logic [I_F_BW-1:0] v);
        logic [WIN_BW-1:0] w;
        for (int i = 0; i < N_TAPS; i++) w[i*I_F_BW +: I_F_BW] = v;
        return w;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the next one.
    task automatic drive_cycle(input bit wv, input logic [WIN_BW-1:0] win, input bit lv,
                               input logic [W_BW-1:0] wd, input logic [B_BW-1:0] bd,
                               input bit use_exp, input logic [O_F_BW-1:0] exp_val);
        exp_t e;
        bus.i_window_valid = wv;
        bus.i_window       = win;
        bus.i_w_valid      = lv;
        bus.i_w_data       = wd;
        bus.i_b_data       = bd;
        if (wv) begin
            if (exp_ready) begin
                e.feat = use_exp ? exp_val : model(win);
                e.cyc  = cyc + 4;
                sb.push_back(e);
            end else begin
                exp_drops++;
            end
        end
        @(posedge clk); #1;
        bus.i_window_valid = 1'b0;
        bus.i_w_valid      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, '0, 0, '0, '0, 0, '0);
    endtask

    task automatic load_bank(input int wts[N_TAPS], input int bias, input bit stream, input bit gap);
        bit was_ready;
        was_ready = exp_ready;
        for (int i = 0; i <= N_TAPS; i++) begin
            if (gap && i == 12) drive_cycle(stream, rand_win(), 0, '0, '0, 0, '0);
            drive_cycle(stream, rand_win(), 1, W_BW'(i < N_TAPS ? wts[i] : 0), B_BW'(bias), 0, '0);
            if (i == 0) begin
                exp_ready = 1'b0;
                if (was_ready) exp_oc = 0;
                n_checks++;
                if (bus.o_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ready_during_load: got %0b, required 0", bus.o_ready);
                end
            end
        end
        drive_cycle(stream, rand_win(), 0, '0, '0, 0, '0);
        tb_w = wts;
        tb_b = bias;
        exp_ready = 1'b1;
        n_checks++;
        if (bus.o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_copy: got %0b, required 1", bus.o_ready);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d outputs pending, required 0", sb.size());
            sb.delete();
        end
        idle(3);
    endtask

    task automatic check_drops(input string name);
        n_checks++;
        if (drops_seen != exp_drops) begin
            n_fail++;
            $display("FAIL drops_%s: got %0d o_drop pulses, required %0d", name, drops_seen, exp_drops);
        end
    endtask

    task automatic test_reset();
        bus.i_window_valid = 0; bus.i_window = '0; bus.i_w_valid = 0; bus.i_w_data = '0; bus.i_b_data = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.o_ready, bus.o_drop, bus.o_valid, bus.o_last} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got ready/drop/valid/last=%b, required 0000",
                     {bus.o_ready, bus.o_drop, bus.o_valid, bus.o_last});
        end
        n_checks++;
        if (bus.o_feature !== '0) begin
            n_fail++;
            $display("FAIL reset_feature: got %0d, required 0", bus.o_feature);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_empty: got %0b, required 0", bus.o_ready);
        end
    endtask

    task automatic test_drop_before_load();
        for (int i = 0; i < 5; i++) drive_cycle(1, rand_win(), 0, '0, '0, 0, '0);
        idle(2);
        check_drops("before_load");
        n_checks++;
        if (valids_seen != 0) begin
            n_fail++;
            $display("FAIL valid_before_load: got %0d outputs, required 0", valids_seen);
        end
    endtask

    task automatic test_basic();
        int w[N_TAPS];
        int v0;
        for (int i = 0; i < N_TAPS; i++) w[i] = 1;
        load_bank(w, 0, 0, 1);
        v0 = valids_seen;
        drive_cycle(1, fill_win(8'd10), 0, '0, '0, 1, 16'd250);
        drain();
        n_checks++;
        if (valids_seen - v0 != 1) begin
            n_fail++;
            $display("FAIL basic_valid_count: got %0d, required 1", valids_seen - v0);
        end
    endtask

    task automatic test_negative();
        int w[N_TAPS];
        logic [O_F_BW-1:0] ev;
        int neg;
        for (int i = 0; i < N_TAPS; i++) w[i] = -1;
        load_bank(w, 0, 0, 0);
        neg = -6375;
`ifdef CNN_CONV_RELU_EN
        ev = '0;
`else
        ev = neg[O_F_BW-1:0];
`endif
        drive_cycle(1, fill_win(8'd255), 0, '0, '0, 1, ev);
        for (int i = 0; i < 4; i++) drive_cycle(1, rand_win(), 0, '0, '0, 0, '0);
        drain();
    endtask

    task automatic test_saturation();
        int w[N_TAPS];
        logic [O_F_BW-1:0] ev;
        for (int i = 0; i < N_TAPS; i++) w[i] = 127;
        load_bank(w, 32767, 0, 0);
`ifdef CNN_CONV_RELU_EN
        ev = 16'hFFFF;
`else
        ev = 16'h7FFF;
`endif
        drive_cycle(1, fill_win(8'd255), 0, '0, '0, 1, ev);
        drain();
        for (int i = 0; i < N_TAPS; i++) w[i] = -128;
        load_bank(w, -32768, 0, 0);
`ifdef CNN_CONV_RELU_EN
        ev = 16'h0000;
`else
        ev = 16'h8000;
`endif
        drive_cycle(1, fill_win(8'd255), 0, '0, '0, 1, ev);
        drain();
    endtask

    task automatic test_reload();
        int w[N_TAPS];
        for (int i = 0; i < N_TAPS; i++) w[i] = i - 12;
        load_bank(w, 100, 0, 0);
        for (int i = 0; i < 6; i++) drive_cycle(1, rand_win(), 0, '0, '0, 0, '0);
        for (int i = 0; i < N_TAPS; i++) w[i] = 3;
        load_bank(w, -50, 1, 0);
        for (int i = 0; i < 6; i++) drive_cycle(1, rand_win(), 0, '0, '0, 0, '0);
        drain();
        check_drops("reload");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) drive_cycle(1, rand_win(), 0, '0, '0, 0, '0);
        reset_n = 1'b0;
        sb.delete();
        exp_ready = 1'b0;
        exp_oc = 0;
        #1;
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got valid=%0b ready=%0b, required 0 0", bus.o_valid, bus.o_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        exp_drops = 0;
        drops_seen = 0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) drive_cycle(1, rand_win(), 0, '0, '0, 0, '0);
        idle(2);
        check_drops("after_reset");
        n_checks++;
        if (bus.o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %0b, required 0", bus.o_ready);
        end
    endtask

    task automatic test_back_to_back();
        int w[N_TAPS];
        int v0, l0;
        for (int i = 0; i < N_TAPS; i++) w[i] = $urandom_range(6) - 3;
        load_bank(w, $urandom_range(200) - 100, 0, 0);
        v0 = valids_seen;
        l0 = lasts_seen;
        for (int i = 0; i < 2 * N_OUT; i++) drive_cycle(1, rand_win(), 0, '0, '0, 0, '0);
        drain();
        n_checks++;
        if (valids_seen - v0 != 2 * N_OUT) begin
            n_fail++;
            $display("FAIL frame_valid_count: got %0d, required %0d", valids_seen - v0, 2 * N_OUT);
        end
        n_checks++;
        if (lasts_seen - l0 != 2) begin
            n_fail++;
            $display("FAIL frame_last_count: got %0d, required 2", lasts_seen - l0);
        end
        check_drops("frame");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_drop_before_load();
        test_basic();
        test_negative();
        test_saturation();
        test_reload();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
